// File: rtl/ttt_referee.sv
// ttt_referee: tic-tac-toe game controller sitting between the move-input stage and nine cells.
//
// A raw move request is turned into a one-cycle move strobe only if it is legal. The controller
// reads back the 18-bit board, judges win or draw, tracks the side to move, keeps per-player
// saturating win counters and clears the cells on a new game.
//
// Optional feature (compile-time macro TTT_LOSER_STARTS_EN):
//   defined   - after new_game the loser of the previous game starts; after a draw the
//               starting player alternates from the previous starter.
//   undefined - X always starts.
//   Reset always starts with X.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   board         in   18-bit board, cell k on [2k+1:2k]: 00 empty, 01 X, 10 O, 11 occupied
//   select        in   one-cycle move request
//   cursor        in   requested cell index, legal range 0..8
//   new_game      in   one-cycle restart request (priority over select)
//   move_out      out  one-cycle legal-move strobe to the cells
//   move_cell     out  cell index accompanying move_out
//   currentPlayer out  side to move: 0 = X, 1 = O
//   cells_clear   out  synchronous clear for all cells
//   illegal       out  one-cycle pulse when a move request is rejected
//   game_state    out  00 play, 01 X won, 10 O won, 11 draw
//   win_line      out  winning lines: [2:0] rows, [5:3] columns, [6] 0/4/8, [7] 2/4/6
//   x_score       out  number of X wins (saturating)
//   o_score       out  number of O wins (saturating)

module ttt_referee #(
    parameter int unsigned SCORE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [17:0]        board,
    input  logic               select,
    input  logic [3:0]         cursor,
    input  logic               new_game,
    output logic               move_out,
    output logic [3:0]         move_cell,
    output logic               currentPlayer,
    output logic               cells_clear,
    output logic               illegal,
    output logic [1:0]         game_state,
    output logic [7:0]         win_line,
    output logic [SCORE_W-1:0] x_score,
    output logic [SCORE_W-1:0] o_score
);

    typedef enum logic [2:0] {StPlay, StIssue, StCheck, StXWin, StOWin, StDraw} state_e;

    localparam logic [SCORE_W-1:0] ScoreMax = '1;

    state_e               state_q;
    logic                 player_q;
    logic                 move_out_q;
    logic [3:0]           move_cell_q;
    logic                 illegal_q;
    logic                 clear_q;
    logic [7:0]           win_line_q;
    logic [3:0]           count_q;
    logic [SCORE_W-1:0]   x_score_q;
    logic [SCORE_W-1:0]   o_score_q;

    logic [1:0]           cell_bits;
    logic                 cell_free;
    logic [1:0]           mark;
    logic [8:0]           match;
    logic [7:0]           lines;
    logic                 next_starter;

    // An out-of-range cursor keeps the default 11 and therefore reads as occupied.
    always_comb begin
        cell_bits = 2'b11;
        for (int k = 0; k < 9; k++) begin
            if (cursor == 4'(k)) begin
                cell_bits = board[2*k +: 2];
            end
        end
    end

    assign cell_free = (cell_bits == 2'b00);
    assign mark      = player_q ? 2'b10 : 2'b01;

    always_comb begin
        match = '0;
        for (int k = 0; k < 9; k++) begin
            match[k] = (board[2*k +: 2] == mark);
        end
    end

    assign lines[0] = match[0] & match[1] & match[2];
    assign lines[1] = match[3] & match[4] & match[5];
    assign lines[2] = match[6] & match[7] & match[8];
    assign lines[3] = match[0] & match[3] & match[6];
    assign lines[4] = match[1] & match[4] & match[7];
    assign lines[5] = match[2] & match[5] & match[8];
    assign lines[6] = match[0] & match[4] & match[8];
    assign lines[7] = match[2] & match[4] & match[6];

`ifdef TTT_LOSER_STARTS_EN
    logic starter_q;

    // A new_game issued mid-game keeps the current starter.
    always_comb begin
        unique case (state_q)
            StXWin:  next_starter = 1'b1;
            StOWin:  next_starter = 1'b0;
            StDraw:  next_starter = ~starter_q;
            default: next_starter = starter_q;
        endcase
    end
`else
    assign next_starter = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StPlay;
            player_q    <= 1'b0;
            move_out_q  <= 1'b0;
            move_cell_q <= '0;
            illegal_q   <= 1'b0;
            clear_q     <= 1'b1;
            win_line_q  <= '0;
            count_q     <= '0;
            x_score_q   <= '0;
            o_score_q   <= '0;
`ifdef TTT_LOSER_STARTS_EN
            starter_q   <= 1'b0;
`endif
        end else begin
            move_out_q <= 1'b0;
            illegal_q  <= 1'b0;
            clear_q    <= 1'b0;
            if (new_game) begin
                clear_q    <= 1'b1;
                state_q    <= StPlay;
                count_q    <= '0;
                win_line_q <= '0;
                player_q   <= next_starter;
`ifdef TTT_LOSER_STARTS_EN
                starter_q  <= next_starter;
`endif
            end else begin
                unique case (state_q)
                    StPlay: begin
                        if (select) begin
                            if (cell_free) begin
                                move_cell_q <= cursor;
                                move_out_q  <= 1'b1;
                                state_q     <= StIssue;
                            end else begin
                                illegal_q <= 1'b1;
                            end
                        end
                    end
                    StIssue: state_q <= StCheck;
                    StCheck: begin
                        // Win is judged before the move count so a 9th-move win is not a draw.
                        if (|lines) begin
                            win_line_q <= lines;
                            if (player_q) begin
                                state_q <= StOWin;
                                if (o_score_q != ScoreMax) o_score_q <= o_score_q + SCORE_W'(1);
                            end else begin
                                state_q <= StXWin;
                                if (x_score_q != ScoreMax) x_score_q <= x_score_q + SCORE_W'(1);
                            end
                        end else if (count_q == 4'd8) begin
                            state_q <= StDraw;
                        end else begin
                            count_q  <= count_q + 4'd1;
                            player_q <= ~player_q;
                            state_q  <= StPlay;
                        end
                    end
                    StXWin, StOWin, StDraw: begin
                        state_q <= state_q;
                    end
                    default: state_q <= StPlay;
                endcase
            end
        end
    end

    always_comb begin
        unique case (state_q)
            StXWin:  game_state = 2'b01;
            StOWin:  game_state = 2'b10;
            StDraw:  game_state = 2'b11;
            default: game_state = 2'b00;
        endcase
    end

    assign move_out      = move_out_q;
    assign move_cell     = move_cell_q;
    assign currentPlayer = player_q;
    assign cells_clear   = clear_q;
    assign illegal       = illegal_q;
    assign win_line      = win_line_q;
    assign x_score       = x_score_q;
    assign o_score       = o_score_q;

endmodule
